// File: rtl/zrb_uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter state encoding and default
// header/abort byte values.
package zrb_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2,
    ST_ABORT  = 2'd3
  } arb_state_t;

  localparam logic [7:0] DEF_HEADER_BASE = 8'hA0;
  localparam logic [7:0] DEF_ABORT_BYTE  = 8'h18;

endpackage

// File: rtl/zrb_rr_pick.sv
// Combinational round-robin picker: returns the first valid index above last_grant,
// wrapping modulo NUM_REQ, plus a flag telling whether any request is valid.
module zrb_rr_pick #(
  parameter  int IDX_W   = 2,
  localparam int NUM_REQ = 1 << IDX_W
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    // The IDX_W-bit add wraps naturally; i == NUM_REQ revisits last_grant itself.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last_grant + IDX_W'(i);
      if (!any && valid[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zrb_tx_arbiter.sv
// Packet-level round-robin arbiter feeding the UART TX FIFO: prefixes each packet with
// a source header byte and cuts off a stalled requester with an abort byte.
module zrb_tx_arbiter
  import zrb_uart_pkg::*;
#(
  parameter  int               IDX_W       = 2,
  parameter  logic [7:0]       HEADER_BASE = DEF_HEADER_BASE,
  parameter  logic [7:0]       ABORT_BYTE  = DEF_ABORT_BYTE,
  parameter  int               TMO_W       = 16,
  parameter  logic [TMO_W-1:0] TIMEOUT     = 16'd50000,
  localparam int               NUM_REQ     = 1 << IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_wr_en,
  output logic [7:0]           fifo_wr_data,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 abort
);

  localparam logic [TMO_W-1:0] TMO_LAST = TIMEOUT - 1'b1;

  arb_state_t       state, state_next;
  logic [IDX_W-1:0] last_grant;
  logic [TMO_W-1:0] timer, timer_next;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             pkt_done;

  zrb_rr_pick #(.IDX_W(IDX_W)) u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  always_comb begin
    state_next   = state;
    timer_next   = timer;
    pkt_done     = 1'b0;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    unique case (state)
      ST_IDLE: begin
        if (pick_any) state_next = ST_HEADER;
      end
      ST_HEADER: begin
        if (!fifo_full) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = HEADER_BASE + 8'(grant_idx);
          timer_next   = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        req_ready[grant_idx] = !fifo_full;
        if (req_valid[grant_idx]) begin
          // A full FIFO with data pending is back-pressure, not a stall: timer holds.
          if (!fifo_full) begin
            fifo_wr_en   = 1'b1;
            fifo_wr_data = req_data[8*grant_idx +: 8];
            timer_next   = '0;
            if (req_last[grant_idx]) begin
              pkt_done   = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end else if (timer == TMO_LAST) begin
          state_next = ST_ABORT;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      ST_ABORT: begin
        if (!fifo_full) begin
          fifo_wr_en   = 1'b1;
          fifo_wr_data = ABORT_BYTE;
          pkt_done     = 1'b1;
          state_next   = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_grant  <= '1;
      timer       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      abort       <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      abort <= (state == ST_ABORT) && !fifo_full;
      if (state == ST_IDLE && pick_any) begin
        grant_idx   <= pick_idx;
        grant_valid <= 1'b1;
      end
      if (pkt_done) begin
        last_grant  <= grant_idx;
        grant_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zrb_tx_arbiter.sv
// Scoreboard bench for zrb_tx_arbiter: a round-robin model predicts the FIFO byte
// stream (with inter-write cycle gaps) for each batch of requester packets.
module tb_zrb_tx_arbiter;

  localparam int               IDX_W   = 2;
  localparam int               NUM_REQ = 1 << IDX_W;
  localparam logic [7:0]       HBASE   = 8'hA0;
  localparam logic [7:0]       ABYTE   = 8'h18;
  localparam logic [15:0]      TMO     = 16'd8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 fifo_full;
  logic                 fifo_wr_en;
  logic [7:0]           fifo_wr_data;
  logic                 grant_valid;
  logic [IDX_W-1:0]     grant_idx;
  logic                 abort;

  zrb_tx_arbiter #(
    .IDX_W(IDX_W), .HEADER_BASE(HBASE), .ABORT_BYTE(ABYTE), .TMO_W(16), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .grant_valid(grant_valid),
    .grant_idx(grant_idx), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    bit         eop;
    bit         is_abort;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] src_q[NUM_REQ][$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         last_wr_cyc = 0;
  int         model_last = NUM_REQ - 1;
  bit         use_gap = 1'b1;
  bit         gv_fall_pending = 1'b0;
  bit         abort_pending = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input bit last);
    src_q[r].push_back({last, d});
  endtask

  task automatic push_exp(input logic [7:0] d, input bit eop, input bit ab, input int gap);
    exp_q.push_back('{data: d, eop: eop, is_abort: ab, gap: gap});
  endtask

  // Arbitration model over everything currently queued; a packet whose queued bytes
  // run out without a last flag stalls and ends in an abort byte.
  task automatic build_expect();
    int pos[NUM_REQ];
    bit first = 1'b1;
    bit found;
    bit done;
    int cur;
    logic [8:0] w;
    foreach (pos[i]) pos[i] = 0;
    forever begin
      found = 1'b0;
      cur   = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (model_last + k) % NUM_REQ;
        if (!found && pos[c] < src_q[c].size()) begin
          found = 1'b1;
          cur   = c;
        end
      end
      if (!found) break;
      push_exp(HBASE + 8'(cur), 1'b0, 1'b0, (first || !use_gap) ? 0 : 2);
      first = 1'b0;
      done  = 1'b0;
      while (!done && pos[cur] < src_q[cur].size()) begin
        w = src_q[cur][pos[cur]];
        pos[cur]++;
        push_exp(w[7:0], w[8], 1'b0, use_gap ? 1 : 0);
        done = w[8];
      end
      // TIMEOUT idle cycles in DATA, then the write happens in the ABORT state.
      if (!done) push_exp(ABYTE, 1'b1, 1'b1, use_gap ? int'(TMO) + 1 : 0);
      model_last = cur;
    end
  endtask

  // Monitor/driver: outputs sampled at negedge describe what the next posedge commits.
  always begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (!reset) begin
      if (gv_fall_pending) begin
        check("grant_valid_fall", 32'(grant_valid), 0);
        gv_fall_pending = 1'b0;
      end
      if (abort_pending) begin
        check("abort_pulse", 32'(abort), 1);
        abort_pending = 1'b0;
      end else if (abort) begin
        check("abort_spurious", 32'(abort), 0);
      end
      if (fifo_wr_en) begin
        check("wr_while_full", 32'(fifo_full), 0);
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 32'(fifo_wr_data), 32'h100);
        end else begin
          e = exp_q.pop_front();
          check("wr_data", 32'(fifo_wr_data), 32'(e.data));
          if (e.gap != 0) check("wr_gap", cyc - last_wr_cyc, e.gap);
          if (e.eop) begin
            check("grant_valid_hold", 32'(grant_valid), 1);
            gv_fall_pending = 1'b1;
          end
          if (e.is_abort) abort_pending = 1'b1;
        end
        last_wr_cyc = cyc;
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (req_valid[i] && req_ready[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]       = src_q[i].size() != 0;
      req_data[8*i +: 8] = (src_q[i].size() != 0) ? src_q[i][0][7:0] : 8'h00;
      req_last[i]        = (src_q[i].size() != 0) ? src_q[i][0][8] : 1'b0;
    end
  end

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_exp_size(input int sz, input int budget);
    int n = 0;
    while (exp_q.size() != sz && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_progress", 32'(exp_q.size()), sz);
  endtask

  task automatic check_reset_outputs();
    check("rst_grant_valid", 32'(grant_valid), 0);
    check("rst_grant_idx", 32'(grant_idx), 0);
    check("rst_abort", 32'(abort), 0);
    check("rst_ready", 32'(req_ready), 0);
    check("rst_wr_en", 32'(fifo_wr_en), 0);
    check("rst_wr_data", 32'(fifo_wr_data), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: three-byte packet from requester 0
    add_byte(0, 8'h11, 1'b0);
    add_byte(0, 8'h22, 1'b0);
    add_byte(0, 8'h33, 1'b1);
    build_expect();
    wait_drain(100);

    // 2: requesters 1 and 3 contend; requester 1 only returns after 3
    add_byte(1, 8'h55, 1'b1);
    add_byte(1, 8'h66, 1'b1);
    add_byte(3, 8'h77, 1'b1);
    build_expect();
    wait_drain(100);

    // 3: FIFO full for 10 cycles mid-packet with data pending
    use_gap = 1'b0;
    add_byte(0, 8'h01, 1'b0);
    add_byte(0, 8'h02, 1'b0);
    add_byte(0, 8'h03, 1'b0);
    add_byte(0, 8'h04, 1'b1);
    build_expect();
    wait_exp_size(3, 50);
    fifo_full = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("full_ready", 32'(req_ready), 0);
      check("full_wr_en", 32'(fifo_wr_en), 0);
    end
    @(posedge clk);
    #1;
    fifo_full = 1'b0;
    wait_drain(100);
    use_gap = 1'b1;

    // 4: requester 2 stalls after one byte and is aborted; requester 3 then served
    add_byte(2, 8'h44, 1'b0);
    add_byte(3, 8'h99, 1'b1);
    build_expect();
    wait_drain(100);

    // 5: reset mid-packet; last_grant must return to NUM_REQ-1 so requester 0 wins
    add_byte(1, 8'h5A, 1'b1);
    build_expect();
    wait_drain(100);
    for (int k = 0; k < 5; k++) add_byte(1, 8'hC0 + 8'(k), 1'b0);
    build_expect();
    wait_exp_size(4, 50);
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) src_q[i].delete();
    exp_q.delete();
    gv_fall_pending = 1'b0;
    abort_pending   = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    model_last = NUM_REQ - 1;
    add_byte(2, 8'h41, 1'b1);
    add_byte(0, 8'h31, 1'b0);
    add_byte(0, 8'h32, 1'b1);
    build_expect();
    wait_drain(100);

    // 6: all requesters continuously valid with two 2-byte packets each
    for (int r = 0; r < NUM_REQ; r++) begin
      for (int p = 0; p < 2; p++) begin
        add_byte(r, 8'(r * 16 + p * 2), 1'b0);
        add_byte(r, 8'(r * 16 + p * 2 + 1), 1'b1);
      end
    end
    build_expect();
    wait_drain(200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
